// File: rtl/zap_bp_ram_ctrl.sv
// rtl/zap_bp_ram_ctrl.sv - branch-history RAM port arbiter: reset sweep, lookups, queued counter training
module zap_bp_ram_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_lookup_req,
  input  logic [31:0]      i_lookup_pc,
  output logic             o_lookup_valid,
  output logic [1:0]       o_lookup_state,
  input  logic             i_clear_from_alu,
  input  logic             i_confirm_from_alu,
  input  logic [31:0]      i_pc_from_alu,
  output logic [IDX_W-1:0] o_ram_addr,
  output logic             o_ram_wen,
  output logic [1:0]       o_ram_wdata,
  input  logic [1:0]       i_ram_rdata,
  output logic             o_init_busy,
  output logic [7:0]       o_drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_CAP,
    UPD_WR
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] init_addr;
  logic [IDX_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       wval;
  logic             lookup_valid_q;
  logic             lookup_zero_q;
  logic [7:0]       drop_cnt;

  logic [IDX_W-1:0] lookup_idx, alu_idx, head_idx;
  logic             head_dir;
  logic             push, pop, full, empty, accept, drop;
  logic             unused_bits;

  assign lookup_idx = i_lookup_pc[IDX_W:1];
  assign alu_idx    = i_pc_from_alu[IDX_W:1];
  assign head_idx   = fifo_mem[rd_ptr][IDX_W-1:0];
  assign head_dir   = fifo_mem[rd_ptr][IDX_W];

  assign push   = i_clear_from_alu | i_confirm_from_alu;
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign unused_bits = ^{i_lookup_pc[31:IDX_W+1], i_lookup_pc[0],
                         i_pc_from_alu[31:IDX_W+1], i_pc_from_alu[0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_ram_addr  = head_idx;
    o_ram_wen   = 1'b0;
    o_ram_wdata = 2'b00;
    pop         = 1'b0;
    case (state)
      INIT: begin
        o_ram_addr = init_addr;
        o_ram_wen  = 1'b1;
        if (init_addr == {IDX_W{1'b1}}) state_nxt = IDLE;
      end
      IDLE: begin
        if (i_lookup_req) o_ram_addr = lookup_idx;
        else if (!empty) state_nxt = UPD_CAP;
      end
      UPD_CAP: begin
        if (i_lookup_req) o_ram_addr = lookup_idx;
        state_nxt = UPD_WR;
      end
      UPD_WR: begin
        if (i_lookup_req) begin
          o_ram_addr = lookup_idx;
        end else begin
          // A reset arriving in this cycle abandons the pending write.
          o_ram_wen   = !i_reset;
          o_ram_wdata = wval;
          pop         = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      init_addr      <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      wval           <= 2'b00;
      lookup_valid_q <= 1'b0;
      lookup_zero_q  <= 1'b0;
      drop_cnt       <= 8'd0;
    end else begin
      if (state == INIT) init_addr <= init_addr + 1'b1;

      lookup_valid_q <= i_lookup_req;
      lookup_zero_q  <= (state == INIT);

      if (accept) begin
        fifo_mem[wr_ptr] <= {i_clear_from_alu, alu_idx};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;

      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      // The read of the head was issued in IDLE, so its data is on the bus now.
      if (state == UPD_CAP) begin
        if (head_dir) wval <= (i_ram_rdata == 2'd3) ? 2'd3 : i_ram_rdata + 2'd1;
        else          wval <= (i_ram_rdata == 2'd0) ? 2'd0 : i_ram_rdata - 2'd1;
      end
    end
  end

  assign o_lookup_valid = lookup_valid_q;
  assign o_lookup_state = (lookup_valid_q && !lookup_zero_q) ? i_ram_rdata : 2'd0;
  assign o_init_busy    = (state == INIT);
  assign o_drop_cnt     = drop_cnt;

endmodule

// File: tb/tb_zap_bp_ram_ctrl.sv
// tb/tb_zap_bp_ram_ctrl.sv - self-checking bench for zap_bp_ram_ctrl with RAM and queue reference model
module tb_zap_bp_ram_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 9;
  localparam int RAM_N      = 512;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_lookup_req;
  logic [31:0] i_lookup_pc;
  logic        o_lookup_valid;
  logic [1:0]  o_lookup_state;
  logic        i_clear_from_alu;
  logic        i_confirm_from_alu;
  logic [31:0] i_pc_from_alu;
  logic [8:0]  o_ram_addr;
  logic        o_ram_wen;
  logic [1:0]  o_ram_wdata;
  logic [1:0]  ram_rdata;
  logic        o_init_busy;
  logic [7:0]  o_drop_cnt;

  zap_bp_ram_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W)) dut (
    .i_clk              (clk),
    .i_reset            (i_reset),
    .i_lookup_req       (i_lookup_req),
    .i_lookup_pc        (i_lookup_pc),
    .o_lookup_valid     (o_lookup_valid),
    .o_lookup_state     (o_lookup_state),
    .i_clear_from_alu   (i_clear_from_alu),
    .i_confirm_from_alu (i_confirm_from_alu),
    .i_pc_from_alu      (i_pc_from_alu),
    .o_ram_addr         (o_ram_addr),
    .o_ram_wen          (o_ram_wen),
    .o_ram_wdata        (o_ram_wdata),
    .i_ram_rdata        (ram_rdata),
    .o_init_busy        (o_init_busy),
    .o_drop_cnt         (o_drop_cnt)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency, preloaded with nonzero junk.
  logic [1:0] mem [RAM_N];
  logic       mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < RAM_N; i++) mem[i] <= 2'($urandom_range(1, 3));
    end else begin
      if (o_ram_wen) mem[o_ram_addr] <= o_ram_wdata;
      ram_rdata <= mem[o_ram_addr];
    end
  end

  typedef struct {
    logic dir;
    int   idx;
  } upd_t;

  upd_t q[$];
  int   wr_log[$];
  int   cur[RAM_N];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   exp_drop = 0;
  int   cyc = 0;
  bit   prev_req = 0;
  int   prev_exp = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 1) & 32'(RAM_N - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, then check against the model.
  task automatic tick(input logic rst, input logic lreq, input logic [31:0] lpc,
                      input logic clr, input logic cfm, input logic [31:0] apc);
    int   li, ai, nv;
    bit   in_init;
    upd_t u;
    @(negedge clk);
    i_reset            = rst;
    i_lookup_req       = lreq;
    i_lookup_pc        = lpc;
    i_clear_from_alu   = clr;
    i_confirm_from_alu = cfm;
    i_pc_from_alu      = apc;
    #1;
    if (rst) begin
      q.delete();
      exp_drop = 0;
      prev_req = 0;
      cyc      = 0;
      return;
    end
    li      = idx_of(lpc);
    ai      = idx_of(apc);
    in_init = (cyc < RAM_N);
    if (prev_req) begin
      chk("lookup_valid", o_lookup_valid, 1);
      chk("lookup_state", o_lookup_state, prev_exp);
    end else begin
      chk("lookup_valid_idle", o_lookup_valid, 0);
    end
    chk("drop_cnt", o_drop_cnt, exp_drop);
    chk("init_busy", o_init_busy, in_init);
    prev_req = lreq;
    prev_exp = in_init ? 0 : cur[li];
    if (in_init) begin
      chk("sweep_wen", o_ram_wen, 1);
      chk("sweep_addr", o_ram_addr, cyc);
      chk("sweep_wdata", o_ram_wdata, 0);
      cur[cyc] = 0;
    end else begin
      if (lreq) begin
        chk("lookup_no_wen", o_ram_wen, 0);
        chk("lookup_addr", o_ram_addr, li);
      end
      if (o_ram_wen === 1'b1) begin
        chk("write_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          u  = q.pop_front();
          nv = u.dir ? ((cur[u.idx] == 3) ? 3 : cur[u.idx] + 1)
                     : ((cur[u.idx] == 0) ? 0 : cur[u.idx] - 1);
          chk("write_addr", o_ram_addr, u.idx);
          chk("write_data", o_ram_wdata, nv);
          cur[u.idx] = nv;
          wr_log.push_back(nv);
        end
      end
    end
    if (clr || cfm) begin
      if (q.size() < FIFO_DEPTH) begin
        u.dir = clr;
        u.idx = ai;
        q.push_back(u);
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
    cyc++;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(input logic [31:0] pc);
    tick(0, 1, pc, 0, 0, 0);
  endtask

  task automatic upd(input logic clr, input logic cfm, input logic [31:0] pc);
    tick(0, 0, 0, clr, cfm, pc);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() > 0; k++) idle();
    idle();
    chk("drain_empty", q.size(), 0);
  endtask

  int inc_exp[4] = '{1, 2, 3, 3};
  int dec_exp[3] = '{3, 2, 1};

  initial begin
    i_reset = 1'b1; i_lookup_req = 0; i_lookup_pc = 0;
    i_clear_from_alu = 0; i_confirm_from_alu = 0; i_pc_from_alu = 0;
    tick(1, 0, 0, 0, 0, 0);
    mem_init = 1'b0;
    tick(1, 0, 0, 0, 0, 0);

    // Reset values, then the sweep with lookups and an update queued mid-sweep.
    idle();
    chk("rst_valid", o_lookup_valid, 0);
    chk("rst_state", o_lookup_state, 0);
    chk("rst_wen", o_ram_wen, 1);
    chk("rst_addr", o_ram_addr, 0);
    chk("rst_wdata", o_ram_wdata, 0);
    chk("rst_busy", o_init_busy, 1);
    chk("rst_drop", o_drop_cnt, 0);
    while (cyc < 100) idle();
    look(32'd600);
    idle();
    chk("init_lookup_valid", o_lookup_valid, 1);
    chk("init_lookup_state", o_lookup_state, 0);
    while (cyc < 200) idle();
    upd(1, 0, 32'h0000_000A);
    while (cyc < 511) idle();
    look(32'd1022);
    idle();
    chk("init_done_busy", o_init_busy, 0);
    chk("init_last_lookup", o_lookup_state, 0);
    drain();

    // Increment saturation on idx 0x80.
    wr_log.delete();
    for (int k = 0; k < 4; k++) upd(1, 0, 32'h100);
    drain();
    chk("inc_writes", wr_log.size(), 4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++) chk("inc_value", wr_log[k], inc_exp[k]);
    look(32'h100);
    idle();
    chk("inc_lookup", o_lookup_state, 3);

    // Clear wins over confirm, then two decrements.
    wr_log.delete();
    upd(1, 1, 32'h100);
    upd(0, 1, 32'h100);
    upd(0, 1, 32'h100);
    drain();
    chk("dec_writes", wr_log.size(), 3);
    for (int k = 0; k < 3 && k < wr_log.size(); k++) chk("dec_value", wr_log[k], dec_exp[k]);
    look(32'h100);
    idle();
    chk("dec_lookup", o_lookup_state, 1);

    // Lookups hold a captured update in its write state.
    upd(1, 0, 32'h40);
    idle();
    chk("prio_read_wen", o_ram_wen, 0);
    chk("prio_read_addr", o_ram_addr, 32'h20);
    for (int k = 0; k < 10; k++) look($urandom);
    idle();
    chk("prio_write_wen", o_ram_wen, 1);
    chk("prio_write_addr", o_ram_addr, 32'h20);
    drain();

    // Six back-to-back updates into a four-entry queue.
    for (int k = 0; k < 6; k++) begin
      upd(1, 0, 32'h200 + 32'(2 * k));
      if (k == 1 || k == 2) chk("ovf_no_pop", o_ram_wen, 0);
      if (k == 3) chk("ovf_first_pop", o_ram_wen, 1);
    end
    idle();
    chk("ovf_drop", o_drop_cnt, 1);
    drain();

    // Random traffic over a small index set.
    for (int k = 0; k < 1500; k++) begin
      int r;
      logic [31:0] lpc, apc;
      r   = $urandom_range(0, 7);
      lpc = ($urandom & ~32'h3FE) | 32'((32'h1E0 + $urandom_range(0, 7)) << 1);
      apc = ($urandom & ~32'h3FE) | 32'((32'h1E0 + $urandom_range(0, 7)) << 1);
      tick(0, $urandom_range(0, 2) == 0, lpc, r == 0 || r == 2, r == 1 || r == 2, apc);
    end
    drain();
    for (int k = 0; k < 8; k++) look(32'((32'h1E0 + k) << 1));
    idle();

    // Reset while a write is pending.
    upd(0, 1, 32'h40);
    idle();
    idle();
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_mid_no_write", o_ram_wen, 0);
    idle();
    chk("rst_mid_addr", o_ram_addr, 0);
    chk("rst_mid_busy", o_init_busy, 1);
    while (cyc < 530) idle();
    chk("rst_mid_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zap_bp_ram_ctrl.md
# zap_bp_ram_ctrl

Controller for the 512-entry, 2-bit branch-history RAM used by the branch predictor. It owns the single read/write port of that RAM and arbitrates it between fetch-side lookups and ALU-side training updates. It performs the read-modify-write of the saturating counters and sweeps the RAM to zero after reset. It sits between the fetch/predict stage and the ALU feedback path, replacing direct multi-ported register-array access with a single-port BRAM.

## Interface
Parameters:
- FIFO_DEPTH, 4, update queue entries (power of two, ≥2)
- IDX_W, 9, RAM index width (RAM has 2^IDX_W entries)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset: synchronous, active-high, sampled on the rising edge of i_clk
- i_lookup_req  in  1  fetch requests a prediction this cycle
- i_lookup_pc  in  32  PC to predict; index = i_lookup_pc[IDX_W:1]
- o_lookup_valid  out  1  prediction for the previous cycle's request is available
- o_lookup_state  out  2  counter value: 0 SNT, 1 WNT, 2 WT, 3 ST
- i_clear_from_alu  in  1  taken-mispredict feedback: increment counter
- i_confirm_from_alu  in  1  confirm feedback: decrement counter
- i_pc_from_alu  in  32  PC of the trained branch; index = i_pc_from_alu[IDX_W:1]
- o_ram_addr  out  IDX_W  RAM address
- o_ram_wen  out  1  RAM write enable
- o_ram_wdata  out  2  RAM write data
- i_ram_rdata  in  2  RAM read data, valid one cycle after a read address is presented
- o_init_busy  out  1  reset sweep in progress
- o_drop_cnt  out  8  count of updates dropped because the queue was full; saturates at 255

## Operation
- **FSM states:** INIT, IDLE, UPD_CAP, UPD_WR.
- **INIT**
  - Entered on reset. An address counter runs 0 to 2^IDX_W−1, writing 2'b00 (o_ram_wen=1) every cycle.
  - After the last address is written, the FSM goes to IDLE. o_init_busy=1 throughout INIT.
- **Lookup priority:** a lookup always has priority for the port. In any non-INIT state, i_lookup_req=1 drives o_ram_addr=i_lookup_pc[IDX_W:1] with o_ram_wen=0.
- **Lookup during INIT:** the lookup does not touch the RAM. It returns o_lookup_state=0 next cycle with o_lookup_valid=1.
- **Update enqueue**
  - Any cycle with i_clear_from_alu|i_confirm_from_alu enqueues {dir, idx}; dir=1 means increment.
  - If both are asserted, clear wins (dir=1). Enqueue is allowed in every state, including INIT.
  - On a full queue with no pop in the same cycle, the entry is dropped and o_drop_cnt increments.
  - Push and pop in the same cycle on a full queue are accepted.
- **IDLE:** if the queue is non-empty and there is no lookup, issue a read of the head idx and go to UPD_CAP. Otherwise stay in IDLE.
- **UPD_CAP**
  - Capture i_ram_rdata and compute the saturating value into a write-value register: increment stops at 3, decrement stops at 0.
  - Go to UPD_WR. The port is free for a lookup in this cycle.
- **UPD_WR**
  - With no lookup: write the register value to the head idx (o_ram_wen=1), pop the queue, go to IDLE.
  - With a lookup: the lookup takes the port and the FSM stays in UPD_WR with the value held.
- **Read/write ordering:** updates are strictly serial, so back-to-back updates to the same idx accumulate correctly.
- **No bypass:** a lookup may see a pre-update value. Predictions are hints.
- **Reset mid-operation:** the queue is emptied, any pending write is abandoned, o_drop_cnt is cleared, and the sweep restarts at address 0.

## Timing
- **Reset values:** o_lookup_valid=0, o_lookup_state=0, o_ram_wen=1 (sweep starts), o_ram_addr=0, o_ram_wdata=0, o_init_busy=1, o_drop_cnt=0.
- **Sweep:** takes 2^IDX_W cycles (512 at the default). o_init_busy falls in the first cycle after the address-511 write.
- **Lookup latency:** a lookup at cycle N gives o_lookup_valid=1 at N+1, with o_lookup_state=i_ram_rdata (or 0 if issued in INIT). o_lookup_valid is registered; o_lookup_state is combinational from the RAM in that cycle.
- **Update latency:** with no lookups, an update is read at N, captured at N+1 and written at N+2; the next update's read is at N+3. Throughput is 1 update per 3 cycles.
- **Stalling:** each lookup in UPD_WR or IDLE delays the update by one cycle. A continuous lookup stream stalls updates indefinitely; this is acceptable by design.

## Test plan
- **Reset sweep:** reset, then run 512 cycles. Required: addresses 0..511 are each written with 0 exactly once, o_init_busy drops at cycle 512, and a lookup mid-sweep returns state 0 with valid=1.
- **Increment saturation:** four clears to PC 0x100 (idx 0x80), then a lookup of PC 0x100. Required: states 1, 2, 3, 3 are written and the lookup returns 3.
- **Decrement and clear-wins:** from state 3, assert clear and confirm together, then confirm twice. Required: writes 3, 2, 1; the final lookup returns 1.
- **Lookup priority:** continuous lookups for 10 cycles while one update is pending. Required: no o_ram_wen until the lookups stop; the write lands 1 cycle after the last lookup, and every lookup is valid 1 cycle after its request.
- **Queue overflow:** 6 updates on consecutive cycles in IDLE with FIFO_DEPTH=4. Required: the first pops after 3 cycles, exactly 1 update is dropped, and o_drop_cnt=1.
- **Reset mid-update:** assert i_reset while in UPD_WR. Required: no write of the pending value, the queue is empty, and the sweep restarts at address 0.
